cmp_share_arbiter: RTL and testbench
====================================

Name: cmp_share_arbiter

Overview:
- Shares one eqNE_ equality/inequality comparator among NUM_REQ requesters, e.g. the BEQ/BNE branch unit and the trap/compare unit.
- Uses round-robin arbitration and valid/ready handshakes on both the request and response sides.
- Has a two-stage registered pipeline: operand stage, then response stage.
- Sits between decode/execute requesters and the shared comparator in the CPU datapath.

Parameters:
- NUM_BITS, 32, operand width passed to eqNE_.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (minimum 1), width of the requester index.
- CNT_W, 16, width of the completed-compare counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline clear, e.g. on mispredict.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_data1  in  NUM_REQ*NUM_BITS  operand A; requester i occupies slice [i*NUM_BITS +: NUM_BITS].
- req_data2  in  NUM_REQ*NUM_BITS  operand B, same slicing.
- req_is_bne  in  NUM_REQ  1 = report not_equal as taken, 0 = report equal.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that is being answered.
- rsp_taken  out  1  selected compare result.
- rsp_equal  out  1  raw equal flag.
- cmp_count  out  CNT_W  completed responses; saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both stages are empty.
  - rsp_valid=0, rsp_id=0, rsp_taken=0, rsp_equal=0, cmp_count=0.
  - RR pointer=0 and req_ready=0.
- Stages:
  - S1 holds valid, id, data1, data2 and is_bne.
  - S2 holds the response registers.
- Advance rules:
  - s2_free = !rsp_valid || rsp_ready.
  - S1 advances into S2 when S1 is valid and s2_free.
  - s1_free = !s1_valid || s2_free.
- Grant:
  - When s1_free and !flush, grant the first requester with req_valid set, searching from the RR pointer upward with wrap-around.
  - req_ready is high only for the granted requester.
  - It is combinational from req_valid, the pointer, stage state and flush.
- Accept: req_valid[i] && req_ready[i] at an edge loads S1 and sets the pointer to (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Compare:
  - eqNE_ runs combinationally on the S1 operands.
  - On advance, S2 captures rsp_equal=equal and rsp_taken = is_bne ? not_equal : equal, plus the id.
- Latency and throughput:
  - A request accepted at edge E gives rsp_valid high after edge E+1.
  - Sustained throughput is 1 per cycle while rsp_ready=1.
- Backpressure:
  - rsp_valid && !rsp_ready holds all S2 outputs stable.
  - S1 also holds if it is full, and req_ready stays 0.
  - There is no loss and no duplication.
- Response completion: when rsp_valid && rsp_ready at an edge, cmp_count increments and saturates at 2^CNT_W-1. If no new S1 data arrives at the same edge, rsp_valid falls.
- Flush:
  - At the edge, both stages are cleared and rsp_valid=0.
  - No request is accepted that cycle (req_ready=0).
  - The pointer and cmp_count are unchanged; a response handshaken at the flush edge is not counted.
- Flush takes priority over every simultaneous event.
- Simultaneous events: a request can be accepted in the same cycle that S1 advances, S2 drains and the next request enters S1.
- Reset in mid-operation: in-flight compares are discarded and no response is produced afterwards.

Decomposition:
- Package cmp_share_pkg holds:
  - the localparam defaults;
  - typedef s1_t (valid, id, data1, data2, is_bne);
  - typedef rsp_t (id, taken, equal).
- Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, enable; output one-hot gnt. This keeps fairness logic separately testable.
- eqNE_ is instantiated unchanged as the shared comparator.

Test Plan:
- Reset then single request: requester 0 sends data1=16, data2=32, is_bne=0 -> after 2 edges rsp_valid=1, rsp_id=0, rsp_taken=0, rsp_equal=0, cmp_count=1.
- BNE case: requester 1 sends 32/32 with is_bne=1 -> rsp_taken=0, rsp_equal=1. Then it sends 5/7 with is_bne=1 -> rsp_taken=1.
- Contention: both requesters hold valid for 4 cycles with rsp_ready=1 -> grants alternate 0,1,0,1, rsp_id follows 2 cycles later, and one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with both requesters valid -> rsp outputs stay stable, req_ready=0 after S1 fills, and no response is lost when rsp_ready returns.
- Flush: assert flush with both stages full -> next cycle rsp_valid=0, no grant that cycle, cmp_count unchanged, and the next request still completes normally.
- Saturation and async reset: with CNT_W=2, 5 responses -> cmp_count=3. Dropping rst_n mid-compare clears outputs immediately, with no clock edge needed.

Source files
------------

// File: rtl/cmp_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_share_pkg
// Description : Shared defaults and stage record types for the shared
//               equality/inequality comparator arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_share_pkg;

    localparam int C_NUM_BITS = 32;
    localparam int C_NUM_REQ  = 2;
    localparam int C_ID_W     = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;
    localparam int C_CNT_W    = 16;

    // Requester index width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operand stage record. Field widths follow the package defaults, so the
    // top-level NUM_BITS / NUM_REQ are tuned together with these constants.
    typedef struct packed {
        logic                  valid;
        logic [C_ID_W-1:0]     id;
        logic [C_NUM_BITS-1:0] data1;
        logic [C_NUM_BITS-1:0] data2;
        logic                  is_bne;
    } s1_t;

    // Response stage record.
    typedef struct packed {
        logic [C_ID_W-1:0] id;
        logic              taken;
        logic              equal;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/eqNE_.sv
`default_nettype none
// ============================================================================
// Module      : eqNE_
// Description : Combinational equality / inequality comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module eqNE_ #(
    parameter int NUM_BITS = 32
) (
    input  logic [NUM_BITS-1:0] data1,
    input  logic [NUM_BITS-1:0] data2,
    output logic                equal,
    output logic                not_equal
);

    assign equal     = (data1 == data2);
    assign not_equal = ~equal;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first asserted request at or
//               above ptr, wrapping around; one-hot or zero grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt
);

    // Walk priority slots starting at ptr; the first live request wins.
    always_comb begin
        logic w_found;
        int   w_slot;
        gnt     = '0;
        w_found = 1'b0;
        w_slot  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_slot = (int'(ptr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enable && !w_found && req[i] && (i == w_slot)) begin
                    gnt[i]  = 1'b1;
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmp_share_arbiter
// Description : Shares one eqNE_ comparator among NUM_REQ requesters with
//               round-robin grant and a two-stage (operand, response)
//               valid/ready pipeline. Counts completed responses.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_share_arbiter
    import cmp_share_pkg::*;
#(
    parameter int NUM_BITS = C_NUM_BITS,
    parameter int NUM_REQ  = C_NUM_REQ,
    parameter int ID_W     = id_width(NUM_REQ),
    parameter int CNT_W    = C_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_data1,
    input  logic [NUM_REQ*NUM_BITS-1:0] req_data2,
    input  logic [NUM_REQ-1:0]          req_is_bne,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic                        rsp_taken,
    output logic                        rsp_equal,
    output logic [CNT_W-1:0]            cmp_count
);

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [ID_W-1:0]  c_last_id  = ID_W'(NUM_REQ - 1);

    s1_t               r_s1;
    rsp_t              r_rsp;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_ptr;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_s2_free;
    logic              w_s1_free;
    logic              w_adv;
    logic              w_arb_en;
    logic              w_acc;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [NUM_BITS-1:0] w_d1;
    logic [NUM_BITS-1:0] w_d2;
    logic              w_bne;
    logic              w_equal;
    logic              w_not_equal;

    // Stage occupancy: S2 can take new data when empty or draining; S1 can
    // take new data when empty or moving into S2 this cycle.
    assign w_s2_free = !r_rsp_valid || rsp_ready;
    assign w_adv     = r_s1.valid && w_s2_free;
    assign w_s1_free = !r_s1.valid || w_s2_free;
    // Reset gating keeps req_ready low while the block is held in reset.
    assign w_arb_en  = w_s1_free && !flush && rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (r_ptr),
        .enable  (w_arb_en),
        .gnt     (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_acc     = |w_gnt;

    // Encode the grant and steer the winning requester's operands.
    always_comb begin
        w_gnt_id = '0;
        w_d1     = '0;
        w_d2     = '0;
        w_bne    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_id = ID_W'(i);
                w_d1     = req_data1[i*NUM_BITS +: NUM_BITS];
                w_d2     = req_data2[i*NUM_BITS +: NUM_BITS];
                w_bne    = req_is_bne[i];
            end
        end
    end

    // Pointer moves to the slot just past the winner.
    assign w_ptr_nxt = (w_gnt_id == c_last_id) ? '0 : w_gnt_id + ID_W'(1);

    eqNE_ #(
        .NUM_BITS  (NUM_BITS)
    ) u_cmp (
        .data1     (r_s1.data1),
        .data2     (r_s1.data2),
        .equal     (w_equal),
        .not_equal (w_not_equal)
    );

    // Operand stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= '0;
            r_ptr <= '0;
        end else if (flush) begin
            r_s1.valid <= 1'b0;
        end else if (w_acc) begin
            r_s1.valid  <= 1'b1;
            r_s1.id     <= w_gnt_id;
            r_s1.data1  <= w_d1;
            r_s1.data2  <= w_d2;
            r_s1.is_bne <= w_bne;
            r_ptr       <= w_ptr_nxt;
        end else if (w_adv) begin
            r_s1.valid <= 1'b0;
        end
    end

    // Response stage: capture the compare result on advance, drop on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (flush) begin
            r_rsp_valid <= 1'b0;
        end else if (w_adv) begin
            r_rsp_valid <= 1'b1;
            r_rsp.id    <= r_s1.id;
            r_rsp.equal <= w_equal;
            r_rsp.taken <= r_s1.is_bne ? w_not_equal : w_equal;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating count of completed response handshakes; flush suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!flush && r_rsp_valid && rsp_ready && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp.id;
    assign rsp_taken = r_rsp.taken;
    assign rsp_equal = r_rsp.equal;
    assign cmp_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_share_arbiter
// Description : Directed self-checking bench for cmp_share_arbiter. A second
//               instance with a 2-bit counter shares the stimulus to observe
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data1;
    logic [63:0] req_data2;
    logic [1:0]  req_is_bne;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic        rsp_taken;
    logic        rsp_equal;
    logic [15:0] cmp_count;

    logic [1:0]  s_req_ready;
    logic        s_rsp_valid;
    logic [0:0]  s_rsp_id;
    logic        s_rsp_taken;
    logic        s_rsp_equal;
    logic [1:0]  s_cmp_count;

    int n_cmp = 0;
    int n_bad = 0;

    cmp_share_arbiter #(.NUM_BITS(32), .NUM_REQ(2), .ID_W(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_is_bne(req_is_bne),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_taken(rsp_taken), .rsp_equal(rsp_equal), .cmp_count(cmp_count)
    );

    cmp_share_arbiter #(.NUM_BITS(32), .NUM_REQ(2), .ID_W(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_data1(req_data1), .req_data2(req_data2), .req_is_bne(req_is_bne),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_taken(s_rsp_taken), .rsp_equal(s_rsp_equal), .cmp_count(s_cmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b, input logic bne);
        req_data1[idx*32 +: 32] = a;
        req_data2[idx*32 +: 32] = b;
        req_is_bne[idx]         = bne;
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id, input logic tk, input logic eq);
        check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        if (v) begin
            check({tag, ".id"},    32'(rsp_id),    32'(id));
            check({tag, ".taken"}, 32'(rsp_taken), 32'(tk));
            check({tag, ".equal"}, 32'(rsp_equal), 32'(eq));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = 2'b00;
        req_data1  = '0;
        req_data2  = '0;
        req_is_bne = 2'b00;
        rsp_ready  = 1'b1;

        // Reset state
        #3;
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_id",    32'(rsp_id),    32'd0);
        check("rst.taken",     32'(rsp_taken), 32'd0);
        check("rst.equal",     32'(rsp_equal), 32'd0);
        check("rst.count",     32'(cmp_count), 32'd0);
        check("rst.sat_count", 32'(s_cmp_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single request from requester 0: 16 vs 32, BEQ
        set_req(0, 32'd16, 32'd32, 1'b0);
        req_valid = 2'b01;
        #1 check("single.ready", 32'(req_ready), 32'b01);
        step();
        req_valid = 2'b00;
        check("single.lat1", 32'(rsp_valid), 32'd0);
        step();
        check_rsp("single", 1'b1, 1'b0, 1'b0, 1'b0);
        check("single.count_pre", 32'(cmp_count), 32'd0);
        step();
        check("single.count", 32'(cmp_count), 32'd1);
        check("single.drain", 32'(rsp_valid), 32'd0);

        // BNE from requester 1: 32/32 then 5/7 back to back
        set_req(1, 32'd32, 32'd32, 1'b1);
        req_valid = 2'b10;
        #1 check("bne.ready0", 32'(req_ready), 32'b10);
        step();
        set_req(1, 32'd5, 32'd7, 1'b1);
        #1 check("bne.ready1", 32'(req_ready), 32'b10);
        step();
        req_valid = 2'b00;
        check_rsp("bne.eq", 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check_rsp("bne.ne", 1'b1, 1'b1, 1'b1, 1'b0);
        check("bne.count", 32'(cmp_count), 32'd2);
        step();
        check("bne.count2", 32'(cmp_count), 32'd3);
        check("bne.drain", 32'(rsp_valid), 32'd0);

        // Contention: both requesters valid for four cycles
        set_req(0, 32'd1, 32'd1, 1'b0);
        set_req(1, 32'd1, 32'd2, 1'b0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("rr.ready%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
            step();
            if (k == 3) req_valid = 2'b00;
            if (k == 0) check("rr.rsp0", 32'(rsp_valid), 32'd0);
            else check_rsp($sformatf("rr.rsp%0d", k), 1'b1, 1'((k - 1) % 2), ((k - 1) % 2) == 0, ((k - 1) % 2) == 0);
        end
        step();
        check_rsp("rr.rsp4", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("rr.drain", 32'(rsp_valid), 32'd0);
        check("rr.count", 32'(cmp_count), 32'd7);

        // Backpressure: rsp_ready low for three cycles with both requesters valid
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1 check("bp.ready_a", 32'(req_ready), 32'b01);
        step();
        #1 check("bp.ready_b", 32'(req_ready), 32'b10);
        check("bp.rsp_a", 32'(rsp_valid), 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            check_rsp($sformatf("bp.hold%0d", k), 1'b1, 1'b0, 1'b1, 1'b1);
            check($sformatf("bp.ready_full%0d", k), 32'(req_ready), 32'b00);
            check($sformatf("bp.count%0d", k), 32'(cmp_count), 32'd7);
            if (k < 2) step();
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        step();
        check_rsp("bp.rel0", 1'b1, 1'b0 ^ 1'b1, 1'b0, 1'b0);
        check("bp.count_rel0", 32'(cmp_count), 32'd8);
        step();
        check("bp.drain", 32'(rsp_valid), 32'd0);
        check("bp.count_rel1", 32'(cmp_count), 32'd9);

        // Flush with both stages full
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        step();
        req_valid = 2'b10;
        #1 check("fl.ready_fill", 32'(req_ready), 32'b10);
        step();
        check("fl.s2_full", 32'(rsp_valid), 32'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1 check("fl.ready_flush", 32'(req_ready), 32'b00);
        step();
        flush     = 1'b0;
        req_valid = 2'b00;
        check("fl.rsp_valid", 32'(rsp_valid), 32'd0);
        check("fl.count", 32'(cmp_count), 32'd9);
        step();
        check("fl.empty", 32'(rsp_valid), 32'd0);
        set_req(0, 32'd9, 32'd9, 1'b1);
        req_valid = 2'b01;
        #1 check("fl.ready_after", 32'(req_ready), 32'b01);
        step();
        req_valid = 2'b00;
        step();
        check_rsp("fl.after", 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        check("fl.count_after", 32'(cmp_count), 32'd10);
        check("sat.count", 32'(s_cmp_count), 32'd3);

        // Asynchronous reset in mid-operation
        set_req(1, 32'd3, 32'd3, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        check_rsp("ar.before", 1'b1, 1'b1, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        req_valid = 2'b10;
        #1;
        check("ar.rsp_valid", 32'(rsp_valid), 32'd0);
        check("ar.rsp_id",    32'(rsp_id),    32'd0);
        check("ar.taken",     32'(rsp_taken), 32'd0);
        check("ar.equal",     32'(rsp_equal), 32'd0);
        check("ar.count",     32'(cmp_count), 32'd0);
        check("ar.sat_count", 32'(s_cmp_count), 32'd0);
        check("ar.ready",     32'(req_ready), 32'b00);
        step();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("ar.quiet%0d", k), 32'(rsp_valid), 32'd0);
        end
        check("ar.count_after", 32'(cmp_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
